// File: rtl/ot_sha3_pkg.sv
// Shared types, constants and helpers for the SHA3 squeeze/digest stage.
package ot_sha3_pkg;

    localparam int unsigned StateW     = 1600;
    localparam int unsigned WordW      = 64;
    localparam int unsigned StateWords = StateW / WordW;

    typedef enum logic [2:0] {
        L128 = 3'h0,
        L224 = 3'h1,
        L256 = 3'h2,
        L384 = 3'h3,
        L512 = 3'h4
    } keccak_strength_e;

    typedef logic [3:0] mubi4_t;
    localparam mubi4_t MuBi4True  = 4'h6;
    localparam mubi4_t MuBi4False = 4'h9;

    typedef logic [3:0] lc_tx_t;
    localparam lc_tx_t On  = 4'b0101;
    localparam lc_tx_t Off = 4'b1010;

    typedef enum logic [7:0] {
        ErrNone          = 8'h00,
        ErrSha3SwControl = 8'h05
    } err_code_e;

    typedef struct packed {
        logic      valid;
        err_code_e code;
        logic [23:0] info;
    } err_t;

    // Sparse encodings: any single-bit upset lands on an illegal value
    typedef enum logic [5:0] {
        StSqIdle   = 6'b001010,
        StSqWait   = 6'b110001,
        StSqStream = 6'b011100,
        StSqRun    = 6'b100111,
        StSqDone   = 6'b000101,
        StSqError  = 6'b111010
    } sq_st_sparse_e;

    // Number of 64-bit words in the rate portion for a given strength
    function automatic logic [4:0] keccak_rate_words(keccak_strength_e s);
        logic [4:0] words;
        case (s)
            L128:    words = 5'd21;
            L224:    words = 5'd18;
            L256:    words = 5'd17;
            L384:    words = 5'd13;
            L512:    words = 5'd9;
            default: words = 5'd17;
        endcase
        return words;
    endfunction

    function automatic logic keccak_strength_valid(keccak_strength_e s);
        logic ok;
        case (s)
            L128, L224, L256, L384, L512: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Anything other than the exact Off pattern counts as escalation
    function automatic logic lc_tx_test_true_loose(lc_tx_t v);
        return v != Off;
    endfunction

endpackage

// File: rtl/ot_sha3_state_word_sel.sv
// Unmasks the Keccak state shares and selects one 64-bit word by index.
module ot_sha3_state_word_sel
    import ot_sha3_pkg::*;
#(
    parameter int unsigned Share = 1
) (
    input  logic [StateW-1:0] state_i [Share],
    input  logic [4:0]        word_idx_i,
    output logic [WordW-1:0]  word_o
);

    logic [StateW-1:0] w_xor;

    // XOR all shares, then 25:1 word mux; out-of-range index yields zero
    always_comb begin
        w_xor = '0;
        for (int unsigned s = 0; s < Share; s++) begin
            w_xor = w_xor ^ state_i[s];
        end
        word_o = '0;
        for (int unsigned w = 0; w < StateWords; w++) begin
            if (word_idx_i == 5'(w)) begin
                word_o = w_xor[w*WordW +: WordW];
            end
        end
    end

endmodule

// File: rtl/ot_sha3_squeeze.sv
// Digest extraction stage: streams squeezed Keccak words over valid/ready,
// re-runs the core when a rate block is exhausted and reports completion.
module ot_sha3_squeeze
    import ot_sha3_pkg::*;
#(
    parameter bit          EnMasking = 1'b0,
    parameter int unsigned OutLenW   = 16,
    localparam int unsigned Share    = EnMasking ? 2 : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic [OutLenW-1:0]  out_len_i,
    input  keccak_strength_e    strength_i,
    input  logic                state_valid_i,
    input  logic [StateW-1:0]   state_i [Share],
    output logic                run_o,
    output mubi4_t              done_o,
    output logic                digest_valid_o,
    output logic [WordW-1:0]    digest_data_o,
    output logic                digest_last_o,
    input  logic                digest_ready_i,
    output logic                busy_o,
    input  lc_tx_t              lc_escalate_en_i,
    output err_t                error_o,
    output logic                sparse_fsm_error_o
);

    sq_st_sparse_e     r_st, w_st_d;
    logic [OutLenW-1:0] r_remaining, w_remaining_d;
    logic [4:0]         r_rate, w_rate_d;
    logic [4:0]         r_word_idx, w_word_idx_d;
    logic [4:0]         w_sel_idx;
    logic [WordW-1:0]   r_digest, w_digest_d;
    logic [WordW-1:0]   w_sel_word;
    logic               r_seen_low, w_seen_low_d;
    logic               r_run, w_run_d;
    err_t               r_err, w_err_d;
    logic               w_last;
    logic               w_illegal;

    assign w_last = (r_remaining == OutLenW'(1));

    ot_sha3_state_word_sel #(
        .Share(Share)
    ) u_word_sel (
        .state_i    (state_i),
        .word_idx_i (w_sel_idx),
        .word_o     (w_sel_word)
    );

    // Next-state logic for the squeeze FSM and its datapath registers
    always_comb begin
        w_st_d        = r_st;
        w_remaining_d = r_remaining;
        w_rate_d      = r_rate;
        w_word_idx_d  = r_word_idx;
        w_digest_d    = r_digest;
        w_seen_low_d  = r_seen_low;
        w_run_d       = 1'b0;
        w_illegal     = 1'b0;
        w_sel_idx     = r_word_idx;

        case (r_st)
            StSqIdle: begin
                if (req_i && (out_len_i != '0)) begin
                    w_remaining_d = out_len_i;
                    w_rate_d      = keccak_rate_words(strength_i);
                    w_word_idx_d  = '0;
                    w_st_d        = StSqWait;
                end
            end

            StSqWait: begin
                if (state_valid_i) begin
                    w_digest_d = w_sel_word;
                    w_st_d     = StSqStream;
                end
            end

            StSqStream: begin
                if (!state_valid_i) begin
                    w_st_d = StSqError;
                end else if (digest_ready_i) begin
                    w_remaining_d = (r_remaining != '0) ? r_remaining - OutLenW'(1)
                                                        : r_remaining;
                    w_word_idx_d  = r_word_idx + 5'd1;
                    if (w_last) begin
                        // Last word wins over a coincident rate boundary
                        w_digest_d = '0;
                        w_st_d     = StSqDone;
                    end else if ((r_word_idx + 5'd1) == r_rate) begin
                        w_digest_d   = '0;
                        w_word_idx_d = '0;
                        w_seen_low_d = 1'b0;
                        w_run_d      = 1'b1;
                        w_st_d       = StSqRun;
                    end else begin
                        // Fetch the following word on the handshake edge
                        w_sel_idx  = r_word_idx + 5'd1;
                        w_digest_d = w_sel_word;
                    end
                end
            end

            StSqRun: begin
                // Wait for the core to drop and then re-release the state
                if (!state_valid_i) begin
                    w_seen_low_d = 1'b1;
                end else if (r_seen_low) begin
                    w_seen_low_d = 1'b0;
                    w_st_d       = StSqWait;
                end
            end

            StSqDone: begin
                w_st_d = StSqIdle;
            end

            StSqError: begin
                w_st_d = StSqError;
            end

            default: begin
                w_illegal = 1'b1;
                w_st_d    = StSqError;
            end
        endcase

        if (lc_tx_test_true_loose(lc_escalate_en_i)) begin
            w_st_d  = StSqError;
            w_run_d = 1'b0;
        end
    end

    // Software-control error reporting; one-cycle report per offending request
    always_comb begin
        w_err_d = '0;
        if (req_i) begin
            if (r_st != StSqIdle) begin
                w_err_d.valid   = 1'b1;
                w_err_d.code    = ErrSha3SwControl;
                w_err_d.info[0] = req_i;
            end else begin
                if (out_len_i == '0) begin
                    w_err_d.valid   = 1'b1;
                    w_err_d.code    = ErrSha3SwControl;
                    w_err_d.info[0] = req_i;
                end
                if (!keccak_strength_valid(strength_i)) begin
                    w_err_d.valid   = 1'b1;
                    w_err_d.code    = ErrSha3SwControl;
                    w_err_d.info[1] = 1'b1;
                end
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_st        <= StSqIdle;
            r_remaining <= '0;
            r_rate      <= '0;
            r_word_idx  <= '0;
            r_digest    <= '0;
            r_seen_low  <= 1'b0;
            r_run       <= 1'b0;
            r_err       <= '0;
        end else begin
            r_st        <= w_st_d;
            r_remaining <= w_remaining_d;
            r_rate      <= w_rate_d;
            r_word_idx  <= w_word_idx_d;
            r_digest    <= w_digest_d;
            r_seen_low  <= w_seen_low_d;
            r_run       <= w_run_d;
            r_err       <= w_err_d;
        end
    end

    // Output decode; data is gated so the state never leaks while idle
    always_comb begin
        digest_valid_o     = (r_st == StSqStream);
        digest_data_o      = digest_valid_o ? r_digest : '0;
        digest_last_o      = digest_valid_o && w_last;
        run_o              = r_run;
        done_o             = (r_st == StSqDone) ? MuBi4True : MuBi4False;
        busy_o             = (r_st != StSqIdle);
        error_o            = r_err;
        sparse_fsm_error_o = (r_st == StSqError) || w_illegal;
    end

endmodule

// File: tb/tb_ot_sha3_squeeze.sv
// Randomized self-checking bench for ot_sha3_squeeze (masked variant).
module tb_ot_sha3_squeeze;
    import ot_sha3_pkg::*;

    localparam int unsigned OutLenW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic [OutLenW-1:0] out_len = '0;
    keccak_strength_e  strength = L256;
    logic              state_valid = 1'b0;
    logic [StateW-1:0] state [2];
    logic              run;
    mubi4_t            done;
    logic              dvalid;
    logic [63:0]       ddata;
    logic              dlast;
    logic              dready = 1'b0;
    logic              busy;
    lc_tx_t            esc = Off;
    err_t              err;
    logic              sperr;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [63:0] s0 [25];
    logic [63:0] s1 [25];
    logic [63:0] exp_q [$];
    logic [63:0] got_q [$];

    always #5 clk = ~clk;

    ot_sha3_squeeze #(
        .EnMasking (1'b1),
        .OutLenW   (OutLenW)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .req_i              (req),
        .out_len_i          (out_len),
        .strength_i         (strength),
        .state_valid_i      (state_valid),
        .state_i            (state),
        .run_o              (run),
        .done_o             (done),
        .digest_valid_o     (dvalid),
        .digest_data_o      (ddata),
        .digest_last_o      (dlast),
        .digest_ready_i     (dready),
        .busy_o             (busy),
        .lc_escalate_en_i   (esc),
        .error_o            (err),
        .sparse_fsm_error_o (sperr)
    );

    function automatic int rate_of(input logic [2:0] s);
        case (s)
            3'd0:    return 21;
            3'd1:    return 18;
            3'd2:    return 17;
            3'd3:    return 13;
            3'd4:    return 9;
            default: return 17;
        endcase
    endfunction

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    // Fresh random two-share state; model queues the words one block yields
    task automatic new_block(input int rate);
        for (int i = 0; i < 25; i++) begin
            s0[i] = {$urandom, $urandom};
            s1[i] = {$urandom, $urandom};
            state[0][i*64 +: 64] = s0[i];
            state[1][i*64 +: 64] = s1[i];
        end
        for (int i = 0; i < rate; i++) exp_q.push_back(s0[i] ^ s1[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) sample();
        n_cmp++; if (run !== 1'b0) begin n_err++; $display("FAIL reset_run got=%b exp=0", run); end
        n_cmp++; if (done !== MuBi4False) begin n_err++; $display("FAIL reset_done got=%h exp=%h", done, MuBi4False); end
        n_cmp++; if (dvalid !== 1'b0 || ddata !== 64'h0 || dlast !== 1'b0) begin
            n_err++; $display("FAIL reset_digest got v=%b d=%h l=%b exp 0/0/0", dvalid, ddata, dlast); end
        n_cmp++; if (err !== err_t'(0)) begin n_err++; $display("FAIL reset_error got=%h exp=0", err); end
        n_cmp++; if (busy !== 1'b0 || sperr !== 1'b0) begin
            n_err++; $display("FAIL reset_busy_sperr got=%b%b exp=00", busy, sperr); end
        rst_n = 1'b1;
        sample();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    // Full request acting as the core: drops/re-raises the state after run_o
    task automatic run_stream(input logic [2:0] str, input int len, input int mode,
                              input int gap, input string name);
        int rate = rate_of(str);
        int n = 0, runs = 0, dones = 0, last_hs_n = -1, done_n = -1, low_cnt = 0;
        int first_valid_n = -1, streak = 0;
        bit streak_open = 1'b1, hold = 1'b0, finished = 1'b0, rdy;
        logic [63:0] hold_data = '0;
        exp_q.delete();
        got_q.delete();
        new_block(rate);
        state_valid = 1'b1;
        strength = keccak_strength_e'(str);
        out_len = OutLenW'(len);
        req = 1'b1;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            sample();
            n++;
            if (n == 1) begin
                req = 1'b0;
                n_cmp++; if (err.valid !== (str > 3'd4)) begin
                    n_err++; $display("FAIL %s req_err got=%b exp=%b", name, err.valid, str > 3'd4); end
            end
            if (!dvalid) begin
                n_cmp++; if (ddata !== 64'h0) begin n_err++; $display("FAIL %s leak got=%h exp=0", name, ddata); end
            end
            if (hold) begin
                n_cmp++; if (dvalid !== 1'b1 || ddata !== hold_data) begin
                    n_err++; $display("FAIL %s hold got v=%b d=%h exp v=1 d=%h", name, dvalid, ddata, hold_data); end
            end
            if (dvalid && first_valid_n < 0) first_valid_n = n;
            if (first_valid_n >= 0 && streak_open) begin
                if (dvalid) streak++; else streak_open = 1'b0;
            end
            if (run) begin
                runs++;
                state_valid = 1'b0;
                low_cnt = gap;
            end else if (!state_valid) begin
                if (low_cnt > 0) low_cnt--;
                if (low_cnt == 0) begin
                    new_block(rate);
                    state_valid = 1'b1;
                end
            end
            if (done_n >= 0 && n == done_n + 1) begin
                n_cmp++; if (busy !== 1'b0 || done !== MuBi4False) begin
                    n_err++; $display("FAIL %s after_done got busy=%b done=%h exp 0/%h", name, busy, done, MuBi4False); end
                finished = 1'b1;
            end
            if (done === MuBi4True) begin dones++; done_n = n; end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (n % 4 == 0) || (n % 4 == 3);
                default: rdy = 1'($urandom % 2);
            endcase
            dready = rdy;
            hold = dvalid && !rdy;
            hold_data = ddata;
            if (dvalid && rdy) begin
                got_q.push_back(ddata);
                last_hs_n = n;
                n_cmp++; if (dlast !== (got_q.size() == len)) begin
                    n_err++; $display("FAIL %s last got=%b exp=%b at word %0d", name, dlast, got_q.size() == len, got_q.size() - 1); end
            end
        end
        dready = 1'b0;
        n_cmp++; if (!finished) begin n_err++; $display("FAIL %s timeout got done=%0d exp=1", name, dones); end
        n_cmp++; if (got_q.size() != len) begin n_err++; $display("FAIL %s words got=%0d exp=%0d", name, got_q.size(), len); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_cmp++; if (got_q[k] !== exp_q[k]) begin
                n_err++; $display("FAIL %s word%0d got=%h exp=%h", name, k, got_q[k], exp_q[k]); end
        end
        n_cmp++; if (runs != (len + rate - 1) / rate - 1) begin
            n_err++; $display("FAIL %s runs got=%0d exp=%0d", name, runs, (len + rate - 1) / rate - 1); end
        n_cmp++; if (dones != 1 || done_n != last_hs_n + 1) begin
            n_err++; $display("FAIL %s done got cnt=%0d at=%0d exp cnt=1 at=%0d", name, dones, done_n, last_hs_n + 1); end
        n_cmp++; if (first_valid_n != 2) begin n_err++; $display("FAIL %s latency got=%0d exp=2", name, first_valid_n); end
        if (mode == 0) begin
            n_cmp++; if (streak != ((len < rate) ? len : rate)) begin
                n_err++; $display("FAIL %s b2b got=%0d exp=%0d", name, streak, (len < rate) ? len : rate); end
        end
    endtask

    task automatic test_zero_len();
        strength = L256;
        out_len = '0;
        req = 1'b1;
        sample();
        req = 1'b0;
        n_cmp++; if (err.valid !== 1'b1 || err.code !== ErrSha3SwControl) begin
            n_err++; $display("FAIL zero_len_err got v=%b c=%h exp 1/%h", err.valid, err.code, ErrSha3SwControl); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_len_busy got=%b exp=0", busy); end
        sample();
        n_cmp++; if (err.valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL zero_len_after got v=%b busy=%b exp 0/0", err.valid, busy); end
    endtask

    task automatic test_req_in_stream();
        int hs = 0;
        bit got = 1'b0, seen = 1'b0;
        logic [63:0] d0;
        exp_q.delete();
        new_block(17);
        state_valid = 1'b1;
        strength = L256;
        out_len = 16'd3;
        dready = 1'b0;
        req = 1'b1;
        sample();
        req = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            sample();
            seen = dvalid;
        end
        d0 = ddata;
        n_cmp++; if (!seen || d0 !== exp_q[0]) begin
            n_err++; $display("FAIL rs_first got v=%b d=%h exp v=1 d=%h", seen, d0, exp_q[0]); end
        out_len = 16'd7;
        req = 1'b1;
        sample();
        req = 1'b0;
        n_cmp++; if (err.valid !== 1'b1 || err.code !== ErrSha3SwControl || err.info[0] !== 1'b1) begin
            n_err++; $display("FAIL rs_err got v=%b c=%h i0=%b exp 1/%h/1", err.valid, err.code, err.info[0], ErrSha3SwControl); end
        n_cmp++; if (dvalid !== 1'b1 || ddata !== d0 || busy !== 1'b1) begin
            n_err++; $display("FAIL rs_unchanged got v=%b d=%h b=%b exp 1/%h/1", dvalid, ddata, busy, d0); end
        dready = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            if (dvalid) hs++;
            sample();
            if (done === MuBi4True) got = 1'b1;
        end
        dready = 1'b0;
        n_cmp++; if (!got || hs != 3) begin n_err++; $display("FAIL rs_count got done=%b hs=%0d exp 1/3", got, hs); end
        sample();
    endtask

    task automatic test_escalation();
        exp_q.delete();
        new_block(18);
        state_valid = 1'b1;
        strength = L224;
        out_len = 16'd30;
        dready = 1'b1;
        req = 1'b1;
        sample();
        req = 1'b0;
        repeat (4) sample();
        n_cmp++; if (dvalid !== 1'b1) begin n_err++; $display("FAIL esc_pre got v=%b exp=1", dvalid); end
        esc = On;
        sample();
        n_cmp++; if (sperr !== 1'b1 || dvalid !== 1'b0 || ddata !== 64'h0 || run !== 1'b0) begin
            n_err++; $display("FAIL esc_enter got s=%b v=%b d=%h r=%b exp 1/0/0/0", sperr, dvalid, ddata, run); end
        n_cmp++; if (busy !== 1'b1 || done !== MuBi4False) begin
            n_err++; $display("FAIL esc_busy got b=%b d=%h exp 1/%h", busy, done, MuBi4False); end
        esc = Off;
        out_len = 16'd5;
        req = 1'b1;
        sample();
        req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample();
            n_cmp++; if (sperr !== 1'b1 || dvalid !== 1'b0 || run !== 1'b0) begin
                n_err++; $display("FAIL esc_hold got s=%b v=%b r=%b exp 1/0/0", sperr, dvalid, run); end
        end
        dready = 1'b0;
        rst_n = 1'b0;
        sample();
        rst_n = 1'b1;
        sample();
        n_cmp++; if (sperr !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL esc_reset got s=%b b=%b exp 0/0", sperr, busy); end
    endtask

    task automatic test_reset_midop();
        bit bad = 1'b0;
        exp_q.delete();
        new_block(9);
        state_valid = 1'b1;
        strength = L512;
        out_len = 16'd20;
        dready = 1'b1;
        req = 1'b1;
        sample();
        req = 1'b0;
        repeat (5) sample();
        rst_n = 1'b0;
        repeat (2) begin
            sample();
            if (run !== 1'b0 || done !== MuBi4False || busy !== 1'b0) bad = 1'b1;
        end
        rst_n = 1'b1;
        repeat (12) begin
            sample();
            if (run !== 1'b0 || done !== MuBi4False || busy !== 1'b0 || dvalid !== 1'b0) bad = 1'b1;
        end
        dready = 1'b0;
        n_cmp++; if (bad) begin n_err++; $display("FAIL reset_midop got activity=1 exp=0"); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            int sel = $urandom_range(0, 5);
            logic [2:0] s = (sel == 5) ? 3'd7 : 3'(sel);
            run_stream(s, $urandom_range(1, 40), 2, $urandom_range(1, 5), "random");
        end
        run_stream(3'd7, 20, 0, 2, "bad_strength");
    endtask

    task automatic test_back_to_back();
        run_stream(3'd2, 3, 0, 1, "b2b_a");
        run_stream(3'd4, 10, 0, 1, "b2b_b");
    endtask

    initial begin
        state[0] = '0;
        state[1] = '0;
        test_reset();
        run_stream(3'd2, 4, 0, 1, "l256_len4");
        run_stream(3'd4, 20, 0, 24, "l512_len20");
        run_stream(3'd0, 21, 0, 1, "l128_len21");
        run_stream(3'd3, 30, 1, 3, "backpressure");
        test_zero_len();
        test_req_in_stream();
        test_back_to_back();
        test_random();
        test_reset_midop();
        test_escalation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ot_sha3_squeeze.md
Name: ot_sha3_squeeze

Overview:
- Digest extraction stage directly downstream of the SHA3 core.
- Consumes the exposed Keccak state (state_valid / state shares) during the squeeze phase and streams the requested number of 64-bit output words over a valid/ready interface.
- Issues the manual-run pulse to the core when the rate portion of the state is exhausted, so SHAKE/cSHAKE outputs longer than one block need no SW intervention.
- Signals done to the core once the last word has been delivered.

Parameters:
- EnMasking, 0, 1 = state arrives as two shares, XORed internally at word granularity.
- OutLenW, 16, width of the requested output length in 64-bit words.
- Share, derived: 2 if EnMasking else 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  start-extraction pulse; valid only in StSqIdle
- out_len_i  in  OutLenW  number of 64-bit words to emit; latched on req_i
- strength_i  in  keccak_strength_e  selects the rate; latched on req_i
- state_valid_i  in  1  core is squeezing and the state is released
- state_i  in  StateW x Share  Keccak state shares
- run_o  out  1  one-cycle pulse to the core run input
- done_o  out  mubi4_t  MuBi4True for exactly one cycle after the final word
- digest_valid_o  out  1  output word valid
- digest_data_o  out  64  output word (unmasked)
- digest_last_o  out  1  qualifies the final word of the request
- digest_ready_i  in  1  consumer ready
- busy_o  out  1  high in any state other than StSqIdle
- lc_escalate_en_i  in  lc_tx_t  escalation
- error_o  out  err_t  SW-control error report
- sparse_fsm_error_o  out  1  terminal-state / illegal-encoding indication

Behaviour:
- Reset values: all outputs 0, done_o = MuBi4False, error_o = {0, ErrNone, 0}. FSM resets to StSqIdle.
- Rate words by strength: L128 = 21, L224 = 18, L256 = 17, L384 = 13, L512 = 9. Any other encoding: treat as 17 and flag an error.
- Counters:
  - word_idx, 5 bits: position within the block; resets to 0 on every block.
  - remaining, OutLenW bits: decrements on every handshake and must never underflow.
- FSM states (sparse-encoded via the codebase sparse-FSM flop): StSqIdle, StSqWait, StSqStream, StSqRun, StSqDone, StSqError.
- StSqIdle:
  - req_i with out_len_i != 0: latch length and rate, word_idx = 0, go to StSqWait.
  - req_i with out_len_i == 0: error_o.valid pulse, stay in StSqIdle.
- StSqWait: when state_valid_i is high, load the digest register with the XOR of the shares at word_idx, then go to StSqStream. digest_valid_o rises the cycle after state_valid_i is sampled high (1-cycle latency).
- StSqStream:
  - digest_valid_o is held high and digest_data_o is held stable until digest_ready_i.
  - On each handshake: remaining--, word_idx++.
  - remaining was 1 (digest_last_o high): go to StSqDone.
  - Else word_idx+1 == rate: pulse run_o, go to StSqRun.
  - Else load the next word on the same edge, so back-to-back words stream at one per cycle.
  - If state_valid_i drops while in this state: go to StSqError.
- StSqRun: wait for state_valid_i to fall and then rise again (edge-tracked). Reset word_idx to 0 and return to StSqWait behaviour. run_o is never reasserted in this state.
- StSqDone: done_o = MuBi4True for one cycle, then go to StSqIdle. busy_o falls on the same edge.
- StSqError: terminal. sparse_fsm_error_o = 1, digest_valid_o = 0, run_o = 0. Reached from any state on lc_tx_test_true_loose(lc_escalate_en_i) or on an illegal encoding.
- Error reporting: req_i outside StSqIdle produces an ErrSha3SwControl report with info[0] = req_i. The request is ignored and the FSM is unchanged.
- Simultaneous events: escalation has priority over every other event. A handshake on the last word and a rate boundary in the same cycle goes to StSqDone with no run_o.
- Reset mid-operation: returns to StSqIdle with no done_o and no run_o.
- digest_data_o is zero whenever digest_valid_o is low (no state leakage).

Decomposition:
- ot_sha3_pkg:
  - sq_st_sparse_e encoding
  - rate-words function keccak_rate_words(keccak_strength_e)
  - 64-bit word constant
  - err_t reuse
- Sub-module ot_sha3_state_word_sel: combinational XOR of the shares plus a 25:1 word mux indexed by word_idx.

Test Plan:
- L256, out_len = 4, digest_ready_i always high, state_valid_i high: 4 consecutive words equal to state words 0..3, last on word 3, done_o pulse one cycle later, run_o never asserted.
- L512, out_len = 20: words 0..8, run_o pulse, state_valid_i low for 24 cycles then high; words 0..8 of the new state, another run_o, then 2 words. Total 20 words, exactly 2 run_o pulses.
- L128, out_len = 21: exactly one block, last word index 20, no run_o, done_o asserted.
- Backpressure: ready toggling 1-0-0-1: data held stable while ready is low, no word duplicated or dropped, remaining reaches 0 exactly once.
- req_i with out_len = 0, and req_i while in StSqStream: error_o.valid one cycle with code ErrSha3SwControl, FSM state unchanged.
- lc_escalate_en_i = On mid-stream: StSqError the next cycle, digest_valid_o = 0, sparse_fsm_error_o = 1, state held through later req_i; EnMasking = 1 variant checks digest = share0 ^ share1.
